// File: rtl/writeback_queue.sv
// writeback_queue
// In-order writeback buffer between memory/writeback and the register file.
// Up to LANES retiring results enter per cycle (lane 0 oldest); load data is
// aligned and extended on entry. Up to WPORTS oldest entries drain per cycle.
// A forwarding port returns the youngest queued value for a register.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   in_valid/in_ready           per-lane valid, bundle-level ready
//   in_regwrite, in_memread     lane writes a register / result is load data
//   in_aluout, in_rd            ALU result / raw aligned load word (per lane)
//   in_lsize, in_lsign          load size (0 byte, 1 half, 2/3 word), sign-extend
//   in_addr_lo, in_writereg     load address [1:0] / destination register
//   rf_we, rf_waddr, rf_wdata   register file write ports, port 0 oldest
//   fwd_raddr, fwd_hit, fwd_data forwarding lookup
//   count                       occupied entries
module writeback_queue #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [LANES-1:0]           in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0]           in_regwrite,
  input  logic [LANES-1:0]           in_memread,
  input  logic [LANES*DATA_W-1:0]    in_aluout,
  input  logic [LANES*DATA_W-1:0]    in_rd,
  input  logic [LANES*2-1:0]         in_lsize,
  input  logic [LANES-1:0]           in_lsign,
  input  logic [LANES*2-1:0]         in_addr_lo,
  input  logic [LANES*ADDR_W-1:0]    in_writereg,
  output logic [WPORTS-1:0]          rf_we,
  output logic [WPORTS*ADDR_W-1:0]   rf_waddr,
  output logic [WPORTS*DATA_W-1:0]   rf_wdata,
  input  logic [ADDR_W-1:0]          fwd_raddr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // n never exceeds DEPTH, so one conditional subtraction wraps the pointer.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  // Half select uses only lo[1]; sizes 2 and 3 both pass the whole word.
  function automatic logic [DATA_W-1:0] load_align(input logic [DATA_W-1:0] rd,
                                                   input logic [1:0] lsize,
                                                   input logic lsign,
                                                   input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lo, 3'b000} +: 8];
    h = rd[{lo[1], 4'b0000} +: 16];
    case (lsize)
      2'd0:    return {{(DATA_W-8){b[7] & lsign}}, b};
      2'd1:    return {{(DATA_W-16){h[15] & lsign}}, h};
      default: return rd;
    endcase
  endfunction

  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [ADDR_W-1:0] ent_addr_d [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DATA_W-1:0] ent_data_d [DEPTH];
  logic [PW-1:0]     enq_idx, drn_idx, fwd_idx;
  int                enq_n, drn_n;

  assign in_ready = (DEPTH - int'(count_q)) >= LANES;
  assign count    = count_q;

  // Enqueue: accepted lanes pack contiguously from the tail in lane order.
  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    enq_n      = 0;
    enq_idx    = tail_q;
    for (int i = 0; i < LANES; i++) begin
      if (in_ready && in_valid[i] && in_regwrite[i] &&
          (in_writereg[i*ADDR_W +: ADDR_W] != '0)) begin
        enq_idx             = ptr_add(tail_q, enq_n);
        ent_addr_d[enq_idx] = in_writereg[i*ADDR_W +: ADDR_W];
        ent_data_d[enq_idx] = in_memread[i]
                              ? load_align(in_rd[i*DATA_W +: DATA_W], in_lsize[i*2 +: 2],
                                           in_lsign[i], in_addr_lo[i*2 +: 2])
                              : in_aluout[i*DATA_W +: DATA_W];
        enq_n               = enq_n + 1;
      end
    end
  end

  // Drain: the oldest min(count, WPORTS) entries; an older entry is
  // suppressed when a younger entry drained this cycle targets the same reg.
  always_comb begin
    rf_we    = '0;
    rf_waddr = '0;
    rf_wdata = '0;
    drn_idx  = head_q;
    drn_n    = (int'(count_q) < WPORTS) ? int'(count_q) : WPORTS;
    for (int p = 0; p < WPORTS; p++) begin
      if (p < drn_n) begin
        drn_idx                      = ptr_add(head_q, p);
        rf_we[p]                     = 1'b1;
        rf_waddr[p*ADDR_W +: ADDR_W] = ent_addr_q[drn_idx];
        rf_wdata[p*DATA_W +: DATA_W] = ent_data_q[drn_idx];
        for (int q = 0; q < WPORTS; q++) begin
          if ((q > p) && (q < drn_n) &&
              (ent_addr_q[ptr_add(head_q, q)] == ent_addr_q[drn_idx]))
            rf_we[p] = 1'b0;
        end
      end
    end
  end

  // Forwarding scans oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head_q;
    for (int j = 0; j < DEPTH; j++) begin
      fwd_idx = ptr_add(head_q, j);
      if ((j < int'(count_q)) && (fwd_raddr != '0) && (ent_addr_q[fwd_idx] == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data_q[fwd_idx];
      end
    end
  end

  always_comb begin
    head_d  = ptr_add(head_q, drn_n);
    tail_d  = ptr_add(tail_q, enq_n);
    count_d = CW'(int'(count_q) + enq_n - drn_n);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never observed while count is zero, so it needs no reset.
  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
  end

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  v1, v2, rw, mr, lsign;
  logic [63:0] alu, rd;
  logic [3:0]  lsize, lo;
  logic [9:0]  wr;
  logic [4:0]  fra;

  logic        ready1, hit1;
  logic [0:0]  we1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1, fdata1;
  logic [2:0]  count1;

  logic        ready2, hit2;
  logic [1:0]  we2;
  logic [9:0]  waddr2;
  logic [63:0] wdata2;
  logic [31:0] fdata2;
  logic [2:0]  count2;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  writeback_queue #(.LANES(2), .WPORTS(1), .DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(v1), .in_ready(ready1),
    .in_regwrite(rw), .in_memread(mr), .in_aluout(alu), .in_rd(rd),
    .in_lsize(lsize), .in_lsign(lsign), .in_addr_lo(lo), .in_writereg(wr),
    .rf_we(we1), .rf_waddr(waddr1), .rf_wdata(wdata1),
    .fwd_raddr(fra), .fwd_hit(hit1), .fwd_data(fdata1), .count(count1));

  writeback_queue #(.LANES(2), .WPORTS(2), .DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut2 (
    .clk(clk), .resetn(resetn), .in_valid(v2), .in_ready(ready2),
    .in_regwrite(rw), .in_memread(mr), .in_aluout(alu), .in_rd(rd),
    .in_lsize(lsize), .in_lsign(lsign), .in_addr_lo(lo), .in_writereg(wr),
    .rf_we(we2), .rf_waddr(waddr2), .rf_wdata(wdata2),
    .fwd_raddr(fra), .fwd_hit(hit2), .fwd_data(fdata2), .count(count2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    v1 = '0; v2 = '0; rw = '0; mr = '0; lsign = '0;
    alu = '0; rd = '0; lsize = '0; lo = '0; wr = '0;
  endtask

  task automatic set_alu(input int i, input logic [4:0] r, input logic [31:0] a);
    wr[i*5 +: 5]   = r;
    alu[i*32 +: 32] = a;
    rw[i] = 1'b1;
    mr[i] = 1'b0;
  endtask

  task automatic set_load(input int i, input logic [4:0] r, input logic [31:0] d,
                          input logic [1:0] sz, input logic sg, input logic [1:0] a);
    wr[i*5 +: 5]   = r;
    rd[i*32 +: 32] = d;
    lsize[i*2 +: 2] = sz;
    lo[i*2 +: 2]    = a;
    lsign[i] = sg;
    rw[i] = 1'b1;
    mr[i] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt [10] = '{0, 2, 3, 2, 3, 2, 3, 2, 1, 0};
    int exp_rdy [10] = '{1, 1, 0, 1, 0, 1, 0, 1, 1, 1};
    int b, drained;

    resetn = 1'b0;
    fra    = '0;
    clear();
    #12;
    chk("rst_count", count1, 0);
    chk("rst_we", we1, 0);
    chk("rst_waddr", waddr1, 0);
    chk("rst_wdata", wdata1, 0);
    chk("rst_hit", hit1, 0);
    chk("rst_fdata", fdata1, 0);
    chk("rst_ready", ready1, 1);
    resetn = 1'b1;

    // two lanes, single write port
    set_alu(0, 5'd3, 32'h11);
    set_alu(1, 5'd4, 32'h22);
    v1 = 2'b11;
    #1;
    chk("pair_ready", ready1, 1);
    step();
    clear();
    #1;
    chk("pair_c1_count", count1, 2);
    chk("pair_c1_we", we1, 1);
    chk("pair_c1_addr", waddr1, 3);
    chk("pair_c1_data", wdata1, 32'h11);
    step();
    chk("pair_c2_count", count1, 1);
    chk("pair_c2_addr", waddr1, 4);
    chk("pair_c2_data", wdata1, 32'h22);
    step();
    chk("pair_c3_count", count1, 0);
    chk("pair_c3_we", we1, 0);

    // load alignment
    set_load(0, 5'd6, 32'h80FF7F01, 2'd0, 1'b1, 2'd2);
    set_load(1, 5'd7, 32'h80FF7F01, 2'd0, 1'b0, 2'd2);
    v1 = 2'b11;
    step();
    clear();
    #1;
    chk("lb_signed", wdata1, 32'hFFFFFFFF);
    step();
    chk("lbu", wdata1, 32'h000000FF);
    set_load(0, 5'd6, 32'h80FF7F01, 2'd1, 1'b1, 2'd3);
    set_load(1, 5'd7, 32'h80FF7F01, 2'd3, 1'b0, 2'd0);
    v1 = 2'b11;
    step();
    clear();
    #1;
    chk("lh_signed_lo3", wdata1, 32'hFFFF80FF);
    step();
    chk("lsize3_word", wdata1, 32'h80FF7F01);
    step();
    chk("load_empty", count1, 0);

    // back-to-back bundles, valid held while bundles remain
    b = 0;
    drained = 0;
    for (int c = 0; c < 10; c++) begin
      if (b < 4) begin
        set_alu(0, 5'(8 + 2*b), 32'(8 + 2*b));
        set_alu(1, 5'(9 + 2*b), 32'(9 + 2*b));
        v1 = 2'b11;
      end else begin
        clear();
      end
      #1;
      chk("b2b_count", count1, exp_cnt[c]);
      chk("b2b_ready", ready1, exp_rdy[c]);
      if (we1[0]) begin
        chk("b2b_order", waddr1, 8 + drained);
        drained++;
      end
      if (ready1 && b < 4) b++;
      step();
    end
    clear();
    chk("b2b_drained", drained, 8);
    chk("b2b_bundles", b, 4);

    // forwarding
    set_alu(0, 5'd5, 32'hA);
    set_alu(1, 5'd5, 32'hB);
    v1  = 2'b11;
    fra = 5'd5;
    #1;
    chk("fwd_enq_nomatch", hit1, 0);
    step();
    clear();
    #1;
    chk("fwd_hit", hit1, 1);
    chk("fwd_youngest", fdata1, 32'hB);
    fra = 5'd9;
    #1;
    chk("fwd_miss_hit", hit1, 0);
    chk("fwd_miss_data", fdata1, 0);
    fra = 5'd0;
    #1;
    chk("fwd_r0", hit1, 0);
    fra = 5'd5;
    step();
    chk("fwd_left_hit", hit1, 1);
    chk("fwd_left_data", fdata1, 32'hB);
    step();
    chk("fwd_empty", hit1, 0);
    fra = 5'd0;

    // discards
    set_alu(0, 5'd0, 32'h55);
    set_alu(1, 5'd9, 32'h66);
    rw[1] = 1'b0;
    v1 = 2'b11;
    step();
    clear();
    #1;
    chk("disc_count", count1, 0);
    chk("disc_we", we1, 0);
    set_alu(0, 5'd10, 32'h10);
    rw[0] = 1'b0;
    set_alu(1, 5'd12, 32'h12);
    v1 = 2'b11;
    step();
    clear();
    #1;
    chk("pack_count", count1, 1);
    chk("pack_addr", waddr1, 12);
    chk("pack_data", wdata1, 32'h12);
    step();
    chk("pack_empty", count1, 0);

    // two write ports
    set_alu(0, 5'd7, 32'h70);
    set_alu(1, 5'd7, 32'h77);
    v2 = 2'b11;
    step();
    clear();
    #1;
    chk("w2_same_count", count2, 2);
    chk("w2_same_we", we2, 2'b10);
    chk("w2_same_addr1", waddr2[9:5], 7);
    chk("w2_same_data1", wdata2[63:32], 32'h77);
    step();
    chk("w2_same_empty", count2, 0);
    chk("w2_idle_we", we2, 0);
    chk("w2_idle_addr", waddr2, 0);
    set_alu(0, 5'd1, 32'h1);
    set_alu(1, 5'd2, 32'h2);
    v2 = 2'b11;
    step();
    clear();
    #1;
    chk("w2_both_we", we2, 2'b11);
    chk("w2_both_addr", waddr2, {5'd2, 5'd1});
    chk("w2_both_data", wdata2, {32'h2, 32'h1});
    step();
    chk("w2_both_empty", count2, 0);

    // asynchronous reset with three entries queued
    set_alu(0, 5'd20, 32'h20);
    set_alu(1, 5'd21, 32'h21);
    v1 = 2'b11;
    step();
    set_alu(0, 5'd22, 32'h22);
    set_alu(1, 5'd23, 32'h23);
    step();
    clear();
    #1;
    chk("mid_count3", count1, 3);
    resetn = 1'b0;
    #1;
    chk("arst_count", count1, 0);
    chk("arst_we", we1, 0);
    chk("arst_ready", ready1, 1);
    step();
    resetn = 1'b1;
    step();
    chk("post_rst_count", count1, 0);
    chk("post_rst_we", we1, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
